// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state and opcode encodings for the serial add/sub sequencer
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_bit_cell.sv
// rtl/serial_bit_cell.sv - one-bit full adder/subtractor built from two half stages plus an OR
module serial_bit_cell
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic op,
    output logic out,
    output logic cout
);

    logic p;
    logic g1;
    logic g2;

    // First half stage combines the operand bits; generate is a&b for add, ~a&b for sub.
    assign p  = a ^ b;
    assign g1 = (op == OP_SUB) ? (~a & b) : (a & b);

    // Second half stage folds in the incoming carry/borrow.
    assign out = p ^ cin;
    assign g2  = (op == OP_SUB) ? (~p & cin) : (p & cin);

    assign cout = g1 | g2;

endmodule

// File: rtl/serial_addsub_seq.sv
// rtl/serial_addsub_seq.sv - bit-serial add/sub sequencer, LSB first; SERIAL_ADDSUB_OVF_EN adds the ovf output
module serial_addsub_seq
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cb_out,
    output logic             busy
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   result_sr;
    logic [CNT_W-1:0]   cnt;
    logic               op_q;
    logic               cb_q;
    logic               cb_out_q;
    logic               cell_out;
    logic               cell_cout;
    logic               last_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               ovf_q;
`endif

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_bit_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (cb_q),
        .op   (op_q),
        .out  (cell_out),
        .cout (cell_cout)
    );

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept in IDLE, run WIDTH bit cycles, hold in DONE until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit)  state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, shift one bit pair per cycle, capture final carry/borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            result_sr <= '0;
            cnt       <= '0;
            op_q      <= OP_ADD;
            cb_q      <= 1'b0;
            cb_out_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sr <= a;
                        b_sr <= b;
                        op_q <= op;
                        cb_q <= 1'b0;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    a_sr      <= a_sr >> 1;
                    b_sr      <= b_sr >> 1;
                    result_sr <= {cell_out, result_sr[WIDTH-1:1]};
                    cb_q      <= cell_cout;
                    if (last_bit) begin
                        cb_out_q <= cell_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // Carry into the MSB is the flop value feeding the cell on this cycle.
                        ovf_q    <= cb_q ^ cell_cout;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign result    = result_sr;
    assign cb_out    = cb_out_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
